wrr_pop_scheduler: RTL and testbench

- Weighted round-robin pop controller for the per-class FIFO bank. It sits between the FIFO bank and the single downstream consumer.
- Picks the next non-empty queue in rotating order, issues a burst of up to `weight` pops to it, and forwards the popped words.
- Stalls on downstream back-pressure and presents words with a fixed pipeline latency.

---
 rtl/wrr_pop_scheduler.sv | 114 +++++++++++
 tb/tb_wrr_pop_scheduler.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/wrr_pop_scheduler.sv
// Weighted round-robin pop controller: grants one non-empty FIFO at a time for a
// burst of up to its weight, and forwards popped words with a fixed 2-cycle latency.
module wrr_pop_scheduler #(
  parameter int QUEUE_QUANTITY = 4,
  parameter int DATA_BITS      = 8,
  parameter int WEIGHT_BITS    = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  enb,
  input  logic [QUEUE_QUANTITY-1:0]             buf_empty,
  input  logic [QUEUE_QUANTITY*DATA_BITS-1:0]   fifo_data,
  input  logic [QUEUE_QUANTITY*WEIGHT_BITS-1:0] weights,
  input  logic                                  pause,
  output logic [QUEUE_QUANTITY-1:0]             pop,
  output logic [DATA_BITS-1:0]                  data_out,
  output logic                                  valid_out,
  output logic [$clog2(QUEUE_QUANTITY)-1:0]     current_queue,
  output logic                                  busy
);
  localparam int QW     = $clog2(QUEUE_QUANTITY);
  localparam int STAGES = 2;

  typedef enum logic {IDLE, SERVE} state_t;

  state_t                 state, state_nxt;
  logic [QW-1:0]          ptr, ptr_nxt, cq_nxt, scan_idx, cand;
  logic [WEIGHT_BITS-1:0] burst_cnt, burst_nxt, scan_w;
  logic                   found, go, popping;
  logic [STAGES:1]        vld_pipe;
  logic [QW-1:0]          idx_p1;

  assign go   = enb & ~pause;
  assign busy = (state == SERVE);

  // Rotating priority scan; descending loop so the smallest offset from ptr wins.
  always_comb begin
    found    = 1'b0;
    scan_idx = ptr;
    cand     = ptr;
    for (int k = QUEUE_QUANTITY - 1; k >= 0; k--) begin
      cand = ptr + QW'(k);
      if (!buf_empty[cand]) begin
        found    = 1'b1;
        scan_idx = cand;
      end
    end
    scan_w = weights[scan_idx*WEIGHT_BITS +: WEIGHT_BITS];
  end

  always_comb begin
    pop     = '0;
    popping = (state == SERVE) && go && !buf_empty[current_queue];
    if (popping) pop[current_queue] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cq_nxt    = current_queue;
    burst_nxt = burst_cnt;
    case (state)
      IDLE: begin
        if (found && go) begin
          cq_nxt    = scan_idx;
          burst_nxt = (scan_w == '0) ? WEIGHT_BITS'(1) : scan_w;
          state_nxt = SERVE;
        end
      end
      SERVE: begin
        if (popping) begin
          burst_nxt = burst_cnt - WEIGHT_BITS'(1);
          if (burst_cnt == WEIGHT_BITS'(1)) begin
            state_nxt = IDLE;
            ptr_nxt   = current_queue + QW'(1);
          end
        end else if (buf_empty[current_queue]) begin
          state_nxt = IDLE;
          ptr_nxt   = current_queue + QW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= '0;
      current_queue <= '0;
      burst_cnt     <= '0;
    end else begin
      state         <= state_nxt;
      ptr           <= ptr_nxt;
      current_queue <= cq_nxt;
      burst_cnt     <= burst_nxt;
    end
  end

  // Stage 1 remembers which FIFO was popped; stage 2 captures its read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      idx_p1   <= '0;
      data_out <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], popping};
      if (popping)     idx_p1   <= current_queue;
      if (vld_pipe[1]) data_out <= fifo_data[idx_p1*DATA_BITS +: DATA_BITS];
    end
  end

  assign valid_out = vld_pipe[STAGES];
endmodule

// File: tb/tb_wrr_pop_scheduler.sv
// Randomized bench for wrr_pop_scheduler: a FIFO-bank environment plus a
// cycle-level reference model of the grant/burst rules and the 2-cycle data path.
module tb_wrr_pop_scheduler;
  localparam int QN = 4;
  localparam int DB = 8;
  localparam int WB = 3;

  logic             clk = 1'b0;
  logic             rst, enb, pause;
  logic [QN-1:0]    buf_empty, pop;
  logic [QN*DB-1:0] fifo_data;
  logic [QN*WB-1:0] weights;
  logic [DB-1:0]    data_out;
  logic             valid_out;
  logic [1:0]       current_queue;
  logic             busy;

  wrr_pop_scheduler #(.QUEUE_QUANTITY(QN), .DATA_BITS(DB), .WEIGHT_BITS(WB)) dut (
    .clk(clk), .rst(rst), .enb(enb), .buf_empty(buf_empty), .fifo_data(fifo_data),
    .weights(weights), .pause(pause), .pop(pop), .data_out(data_out),
    .valid_out(valid_out), .current_queue(current_queue), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // FIFO bank environment
  logic [DB-1:0] fq [QN][$];
  logic [DB-1:0] fd [QN];
  logic [7:0]    seqno = 8'h10;

  always_comb
    for (int i = 0; i < QN; i++) fifo_data[i*DB +: DB] = fd[i];

  // reference model state
  bit            m_srv;
  int            m_q, m_rem, m_ptr;
  bit            p1_v, o_v;
  logic [DB-1:0] p1_w, o_w;
  bit            last_pop_q1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < QN; i++) buf_empty[i] = (fq[i].size() == 0);
  endtask

  task automatic push(input int q, input int n);
    for (int j = 0; j < n; j++) begin
      fq[q].push_back(seqno);
      seqno++;
    end
    refresh();
  endtask

  task automatic clear_all();
    for (int i = 0; i < QN; i++) fq[i].delete();
    refresh();
  endtask

  task automatic model_reset();
    m_srv = 0; m_q = 0; m_rem = 0; m_ptr = 0;
    p1_v = 0; o_v = 0; p1_w = '0; o_w = '0;
  endtask

  // One clock: compare outputs against the model, then advance model and FIFOs.
  task automatic cycle();
    logic [QN-1:0] ep;
    bit            pv, n_o_v, emp, fnd;
    logic [DB-1:0] pw, n_o_w;
    int            pq, idx, w;
    #2;
    ep = '0;
    if (m_srv && enb && !pause && fq[m_q].size() > 0) ep[m_q] = 1'b1;
    chk("pop", 32'(pop), 32'(ep));
    chk("valid_out", 32'(valid_out), 32'(o_v));
    if (o_v) chk("data_out", 32'(data_out), 32'(o_w));
    chk("current_queue", 32'(current_queue), 32'(m_q));
    chk("busy", 32'(busy), 32'(m_srv));
    last_pop_q1 = ep[1];
    pq    = m_q;
    emp   = (fq[m_q].size() == 0);
    pv    = (ep != '0);
    pw    = pv ? fq[m_q][0] : p1_w;
    n_o_v = p1_v;
    n_o_w = p1_v ? p1_w : o_w;
    if (!m_srv) begin
      fnd = 0; idx = 0;
      for (int k = 0; k < QN; k++)
        if (!fnd && fq[(m_ptr + k) % QN].size() > 0) begin
          fnd = 1; idx = (m_ptr + k) % QN;
        end
      if (fnd && enb && !pause) begin
        w = int'(weights[idx*WB +: WB]);
        m_srv = 1; m_q = idx; m_rem = (w == 0) ? 1 : w;
      end
    end else if (pv) begin
      m_rem--;
      if (m_rem == 0) begin m_srv = 0; m_ptr = (m_q + 1) % QN; end
    end else if (emp) begin
      m_srv = 0; m_ptr = (m_q + 1) % QN;
    end
    if (rst) begin
      m_srv = 0; m_q = 0; m_rem = 0; m_ptr = 0;
      pv = 0; n_o_v = 0;
    end
    @(posedge clk); #1;
    if (ep != '0) fd[pq] = fq[pq].pop_front();
    p1_v = pv; p1_w = pw; o_v = n_o_v; o_w = n_o_w;
    refresh();
  endtask

  task automatic run(input int n, input int pause_pct, input int enb_off_pct, input int fill_pct);
    repeat (n) begin
      pause = ($urandom_range(99) < pause_pct);
      enb   = ($urandom_range(99) >= enb_off_pct);
      if ($urandom_range(99) < fill_pct) push($urandom_range(QN-1), $urandom_range(4, 1));
      cycle();
    end
  endtask

  initial begin
    int bound;
    int pops;
    for (int i = 0; i < QN; i++) fd[i] = '0;
    rst = 1; enb = 1; pause = 0;
    weights = {3'd1, 3'd1, 3'd1, 3'd1};
    for (int i = 0; i < QN; i++) push(i, 8);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("reset_pop", 32'(pop), 32'h0);
    chk("reset_valid", 32'(valid_out), 32'h0);
    chk("reset_data", 32'(data_out), 32'h0);
    chk("reset_cq", 32'(current_queue), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    rst = 0;
    cycle();
    #2;
    chk("first_pop", 32'(pop), 32'h1);

    // all full, weights 1: one pop per two cycles, rotating
    run(14, 0, 0, 0);

    // weights q0=3 q1=1 q2=2 q3=0
    weights = {3'd0, 3'd2, 3'd1, 3'd3};
    for (int i = 0; i < QN; i++) push(i, 4);
    run(20, 0, 0, 0);

    // q2 runs dry inside its burst
    clear_all();
    run(3, 0, 0, 0);
    weights = {3'd1, 3'd4, 3'd1, 3'd1};
    push(2, 2); push(3, 3);
    run(14, 0, 0, 0);

    // pause after the 2nd of 5 pops to q1, held 4 cycles
    clear_all();
    run(3, 0, 0, 0);
    weights = {3'd1, 3'd1, 3'd5, 3'd1};
    push(1, 8);
    pause = 0; enb = 1;
    pops = 0; bound = 0;
    while (pops < 2 && bound < 20) begin
      cycle();
      if (last_pop_q1) pops++;
      bound++;
    end
    if (pops < 2) chk("q1_pop_timeout", 32'(pops), 32'd2);
    pause = 1;
    repeat (4) cycle();
    pause = 0;
    push(2, 2);
    run(12, 0, 0, 0);

    // only q0 non-empty with ptr at 3, then reset mid-burst
    clear_all();
    push(2, 1);
    run(6, 0, 0, 0);
    weights = {3'd1, 3'd1, 3'd1, 3'd7};
    push(0, 6);
    run(4, 0, 0, 0);
    rst = 1;
    cycle();
    rst = 0;
    #2;
    chk("rst_mid_valid", 32'(valid_out), 32'h0);
    chk("rst_mid_pop", 32'(pop), 32'h0);
    push(1, 3);
    run(10, 0, 0, 0);

    // randomized traffic, weights, pause and enable
    repeat (6) begin
      weights = QN*WB'($urandom);
      run(150, 20, 10, 45);
    end
    run(40, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
